ext_stage: RTL and testbench



---
 rtl/ext_stage.sv | 150 +++++++++++++++
 tb/tb_ext_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ext_stage
//  Purpose  : Registered operand extender. One pipeline stage that produces
//             either an extended immediate (zero / sign / load-upper) or an
//             extended load value (byte / halfword / word picked out of a
//             memory read word). Misaligned loads are flagged and counted in
//             a saturating debug counter.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             in_valid          - an operation is present this cycle
//             stall, flush      - hold the stage / kill the stage
//             mode[2:0]         - operation select
//             imm[IMM_W-1:0]    - immediate field
//             word[DATA_W-1:0]  - memory read data
//             addr_lo[LO_W-1:0] - low address bits of the load
//             out_valid, result, misalign - registered stage outputs
//             err_count[CNT_W-1:0] - saturating misaligned-load count
//  Revision : 1.0  initial release
// ============================================================================
module ext_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int LO_W   = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        mode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] word,
    input  logic [LO_W-1:0]   addr_lo,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              misalign,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [2:0]       c_MODE_ZEXT = 3'd0;
    localparam logic [2:0]       c_MODE_SEXT = 3'd1;
    localparam logic [2:0]       c_MODE_LUI  = 3'd2;
    localparam logic [2:0]       c_MODE_LB   = 3'd3;
    localparam logic [2:0]       c_MODE_LBU  = 3'd4;
    localparam logic [2:0]       c_MODE_LH   = 3'd5;
    localparam logic [2:0]       c_MODE_LHU  = 3'd6;
    localparam logic [2:0]       c_MODE_LW   = 3'd7;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_err_count;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_calc;
    logic              w_misalign;

    // Byte lane addr_lo. The halfword select ignores addr_lo[0]: an odd
    // halfword address is misaligned and its result is zeroed anyway, and
    // dropping the bit keeps the select inside the word.
    assign w_byte = word[{addr_lo, 3'b000} +: 8];
    assign w_half = word[{addr_lo[LO_W-1:1], 4'b0000} +: 16];

    // Sign extension is done by filling with the sign bit first and then
    // overwriting the low field, which works for every legal width pairing
    // (including 2*IMM_W == DATA_W where there is nothing to extend).
    always_comb begin
        w_calc     = '0;
        w_misalign = 1'b0;
        case (mode)
            c_MODE_ZEXT: begin
                w_calc[IMM_W-1:0] = imm;
            end
            c_MODE_SEXT: begin
                w_calc            = {DATA_W{imm[IMM_W-1]}};
                w_calc[IMM_W-1:0] = imm;
            end
            c_MODE_LUI: begin
                w_calc              = {DATA_W{imm[IMM_W-1]}};
                w_calc[2*IMM_W-1:0] = {imm, {IMM_W{1'b0}}};
            end
            c_MODE_LB: begin
                w_calc      = {DATA_W{w_byte[7]}};
                w_calc[7:0] = w_byte;
            end
            c_MODE_LBU: begin
                w_calc[7:0] = w_byte;
            end
            c_MODE_LH: begin
                w_calc       = {DATA_W{w_half[15]}};
                w_calc[15:0] = w_half;
                w_misalign   = addr_lo[0];
            end
            c_MODE_LHU: begin
                w_calc[15:0] = w_half;
                w_misalign   = addr_lo[0];
            end
            c_MODE_LW: begin
                w_calc     = word;
                w_misalign = (addr_lo != '0);
            end
            default: begin
                w_calc = '0;
            end
        endcase
        if (w_misalign) begin
            w_calc = '0;
        end
    end

    // Stage register. Flush beats stall so a killed stage never survives a
    // held pipeline; the counter only moves on an accepted operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_misalign  <= 1'b0;
            r_err_count <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_misalign  <= 1'b0;
        end else if (stall) begin
            r_out_valid <= r_out_valid;
            r_result    <= r_result;
            r_misalign  <= r_misalign;
        end else if (in_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= w_calc;
            r_misalign  <= w_misalign;
            if (w_misalign && (r_err_count != c_CNT_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_misalign  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign misalign  = r_misalign;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ext_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_stage
//  Purpose  : Directed self-checking bench for ext_stage. Two instances:
//             a 32-bit one with a 2-bit counter (saturation reachable) and
//             a 64-bit one with an 8-bit counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ext_stage;

    logic clk;
    logic reset;

    // 32-bit instance
    logic        a_in_valid, a_stall, a_flush;
    logic [2:0]  a_mode;
    logic [15:0] a_imm;
    logic [31:0] a_word;
    logic [1:0]  a_addr_lo;
    logic        a_out_valid, a_misalign;
    logic [31:0] a_result;
    logic [1:0]  a_err_count;

    // 64-bit instance
    logic        b_in_valid, b_stall, b_flush;
    logic [2:0]  b_mode;
    logic [15:0] b_imm;
    logic [63:0] b_word;
    logic [2:0]  b_addr_lo;
    logic        b_out_valid, b_misalign;
    logic [63:0] b_result;
    logic [7:0]  b_err_count;

    int n_checks;
    int n_errors;

    ext_stage #(.DATA_W(32), .IMM_W(16), .LO_W(2), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .stall(a_stall),
        .flush(a_flush), .mode(a_mode), .imm(a_imm), .word(a_word),
        .addr_lo(a_addr_lo), .out_valid(a_out_valid), .result(a_result),
        .misalign(a_misalign), .err_count(a_err_count)
    );

    ext_stage #(.DATA_W(64), .IMM_W(16), .LO_W(3), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .stall(b_stall),
        .flush(b_flush), .mode(b_mode), .imm(b_imm), .word(b_word),
        .addr_lo(b_addr_lo), .out_valid(b_out_valid), .result(b_result),
        .misalign(b_misalign), .err_count(b_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation on the 32-bit instance and clock it in.
    task automatic op_a(input logic v, input logic st, input logic fl, input logic [2:0] m,
                        input logic [15:0] i, input logic [31:0] w, input logic [1:0] lo);
        a_in_valid = v;  a_stall = st; a_flush = fl;
        a_mode = m; a_imm = i; a_word = w; a_addr_lo = lo;
        tick();
    endtask

    task automatic op_b(input logic v, input logic st, input logic [2:0] m,
                        input logic [15:0] i, input logic [63:0] w, input logic [2:0] lo);
        b_in_valid = v; b_stall = st; b_flush = 1'b0;
        b_mode = m; b_imm = i; b_word = w; b_addr_lo = lo;
        tick();
    endtask

    localparam logic [31:0] WA = 32'h80FF7F01;
    logic [31:0] lb_exp [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        lb_exp[0] = 32'h00000001; lb_exp[1] = 32'h0000007F;
        lb_exp[2] = 32'hFFFFFFFF; lb_exp[3] = 32'hFFFFFF80;

        reset = 1'b1;
        a_in_valid = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_mode = 3'd0;
        a_imm = '0; a_word = '0; a_addr_lo = '0;
        b_in_valid = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_mode = 3'd0;
        b_imm = '0; b_word = '0; b_addr_lo = '0;
        // Garbage inputs during reset must not leak through.
        a_in_valid = 1'b1; a_mode = 3'd1; a_imm = 16'hFFFF;
        tick(); tick();
        check("rst_valid", {63'd0, a_out_valid}, 64'd0);
        check("rst_result", {32'd0, a_result}, 64'd0);
        check("rst_misalign", {63'd0, a_misalign}, 64'd0);
        check("rst_err", {62'd0, a_err_count}, 64'd0);
        reset = 1'b0;

        // Immediate modes
        op_a(1, 0, 0, 3'd0, 16'h8001, 32'd0, 2'd0);
        check("zext_valid", {63'd0, a_out_valid}, 64'd1);
        check("zext", {32'd0, a_result}, 64'h00008001);
        op_a(1, 0, 0, 3'd1, 16'h8001, 32'd0, 2'd0);
        check("sext", {32'd0, a_result}, 64'hFFFF8001);
        op_a(1, 0, 0, 3'd2, 16'h8001, 32'd0, 2'd0);
        check("lui", {32'd0, a_result}, 64'h80010000);

        // Byte loads on every lane
        for (int k = 0; k < 4; k++) begin
            op_a(1, 0, 0, 3'd3, 16'h1234, WA, 2'(k));
            check($sformatf("lb_lane%0d", k), {32'd0, a_result}, {32'd0, lb_exp[k]});
            check($sformatf("lb_mis%0d", k), {63'd0, a_misalign}, 64'd0);
        end
        op_a(1, 0, 0, 3'd6, 16'd0, WA, 2'd2);
        check("lhu_2", {32'd0, a_result}, 64'h000080FF);
        op_a(1, 0, 0, 3'd5, 16'd0, WA, 2'd0);
        check("lh_0", {32'd0, a_result}, 64'h00007F01);
        op_a(1, 0, 0, 3'd5, 16'd0, WA, 2'd2);
        check("lh_2", {32'd0, a_result}, 64'hFFFF80FF);
        op_a(1, 0, 0, 3'd7, 16'd0, WA, 2'd0);
        check("lw_0", {32'd0, a_result}, {32'd0, WA});
        check("err_still0", {62'd0, a_err_count}, 64'd0);

        // Misalignment
        op_a(1, 0, 0, 3'd7, 16'd0, WA, 2'd1);
        check("lw1_mis", {63'd0, a_misalign}, 64'd1);
        check("lw1_res", {32'd0, a_result}, 64'd0);
        check("lw1_err", {62'd0, a_err_count}, 64'd1);
        op_a(1, 0, 0, 3'd5, 16'd0, WA, 2'd3);
        check("lh3_mis", {63'd0, a_misalign}, 64'd1);
        check("lh3_res", {32'd0, a_result}, 64'd0);
        check("lh3_err", {62'd0, a_err_count}, 64'd2);
        op_a(1, 0, 0, 3'd4, 16'd0, WA, 2'd3);
        check("lbu3_mis", {63'd0, a_misalign}, 64'd0);
        check("lbu3_res", {32'd0, a_result}, 64'h00000080);
        check("lbu3_err", {62'd0, a_err_count}, 64'd2);
        op_a(1, 0, 0, 3'd6, 16'd0, WA, 2'd1);
        check("lhu1_mis", {63'd0, a_misalign}, 64'd1);
        check("lhu1_err", {62'd0, a_err_count}, 64'd3);

        // Bubble after a valid op
        op_a(0, 0, 0, 3'd1, 16'hFFFF, WA, 2'd0);
        check("bubble_valid", {63'd0, a_out_valid}, 64'd0);
        check("bubble_res", {32'd0, a_result}, 64'd0);

        // Counter cleared by reset, untouched by stalled / flushed misaligned loads
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst2_err", {62'd0, a_err_count}, 64'd0);
        op_a(1, 1, 0, 3'd7, 16'd0, WA, 2'd2);
        check("stall_nocount", {62'd0, a_err_count}, 64'd0);
        op_a(1, 0, 1, 3'd7, 16'd0, WA, 2'd2);
        check("flush_nocount", {62'd0, a_err_count}, 64'd0);
        check("flush_valid", {63'd0, a_out_valid}, 64'd0);
        for (int n = 1; n <= 5; n++) begin
            op_a(1, 0, 0, 3'd7, 16'd0, WA, 2'd3);
            check($sformatf("sat_%0d", n), {62'd0, a_err_count}, (n < 3) ? 64'(n) : 64'd3);
        end

        // Stall holds, flush overrides stall
        op_a(1, 0, 0, 3'd1, 16'hFFFF, 32'd0, 2'd0);
        check("sext_ffff", {32'd0, a_result}, 64'hFFFFFFFF);
        for (int s = 0; s < 3; s++) begin
            op_a(1, 1, 0, 3'(s), 16'h1234 + 16'(s), WA, 2'(s));
            check($sformatf("stall_res%0d", s), {32'd0, a_result}, 64'hFFFFFFFF);
            check($sformatf("stall_vld%0d", s), {63'd0, a_out_valid}, 64'd1);
        end
        op_a(1, 1, 1, 3'd1, 16'hFFFF, 32'd0, 2'd0);
        check("stflush_valid", {63'd0, a_out_valid}, 64'd0);
        check("stflush_res", {32'd0, a_result}, 64'd0);
        op_a(1, 0, 0, 3'd0, 16'hABCD, 32'd0, 2'd0);
        check("after_stall", {32'd0, a_result}, 64'h0000ABCD);
        a_in_valid = 1'b0;

        // 64-bit instance
        op_b(1, 0, 3'd2, 16'h8000, 64'd0, 3'd0);
        check("b_lui", b_result, 64'hFFFFFFFF80000000);
        check("b_lui_valid", {63'd0, b_out_valid}, 64'd1);
        op_b(1, 0, 3'd3, 16'd0, 64'h8100000000000000, 3'd7);
        check("b_lb7", b_result, 64'hFFFFFFFFFFFFFF81);
        op_b(1, 0, 3'd6, 16'd0, 64'h0123456789ABCDEF, 3'd6);
        check("b_lhu6", b_result, 64'h0000000000000123);
        op_b(1, 0, 3'd7, 16'd0, 64'h0123456789ABCDEF, 3'd0);
        check("b_lw0", b_result, 64'h0123456789ABCDEF);
        op_b(1, 0, 3'd7, 16'd0, 64'h0123456789ABCDEF, 3'd4);
        check("b_lw4_mis", {63'd0, b_misalign}, 64'd1);
        check("b_lw4_res", b_result, 64'd0);
        check("b_err", {56'd0, b_err_count}, 64'd1);

        // Reset mid-stream while stalled
        b_stall = 1'b1; a_stall = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("b_rst_valid", {63'd0, b_out_valid}, 64'd0);
        check("b_rst_res", b_result, 64'd0);
        check("b_rst_mis", {63'd0, b_misalign}, 64'd0);
        check("b_rst_err", {56'd0, b_err_count}, 64'd0);
        check("a_rst_err", {62'd0, a_err_count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
